// File: rtl/wbit_deser_pkg.sv
// Shared types and helpers for the W-bit serial deserializer.
package wbit_deser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  localparam logic DIR_LSB_IN = 1'b0;
  localparam logic DIR_MSB_IN = 1'b1;

  // Bits needed to count 0..w inclusive.
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/wbit_deserializer_shift_core.sv
// Shift register holding the in-progress word; exposes its next value so the
// top level can latch a completed word on the same edge as its final bit.
module deser_shift_core
  import wbit_deser_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         dir,
  input  logic         sin,
  output logic [W-1:0] word_next
);

  logic [W-1:0] sr;

  always_comb begin
    word_next = sr;
    if (clr) begin
      word_next = '0;
    end else if (en) begin
      if (dir == DIR_MSB_IN) begin
        word_next = {sin, sr[W-1:1]};
      end else begin
        word_next = {sr[W-2:0], sin};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= word_next;
    end
  end

endmodule

// File: rtl/wbit_deserializer.sv
// Serial-to-parallel receiver with holding register and valid/ready output.
// Optional even-parity bit after each word when DESER_PARITY_EN is defined.
module wbit_deserializer
  import wbit_deser_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RES,
  input  logic         SIN,
  input  logic         SEN,
  input  logic         LEN,
  input  logic         CLR,
  input  logic         RDY,
  output logic [W-1:0] Out,
  output logic         VLD,
  output logic         BUSY,
  output logic         OVR,
  output logic         PERR
);

  localparam int CW = count_width(W);

  state_t        state, state_nx;
  logic [CW-1:0] count, count_nx;
  logic          dir, dir_nx;
  logic          shift_en, shift_dir, done;
  logic [W-1:0]  word_next;
`ifdef DESER_PARITY_EN
  logic          perr_nx;
`endif

  deser_shift_core #(.W(W)) u_core (
    .clk       (CLK),
    .rst_n     (RES),
    .clr       (CLR),
    .en        (shift_en),
    .dir       (shift_dir),
    .sin       (SIN),
    .word_next (word_next)
  );

  always_comb begin
    state_nx  = state;
    count_nx  = count;
    dir_nx    = dir;
    shift_en  = 1'b0;
    shift_dir = dir;
    done      = 1'b0;
`ifdef DESER_PARITY_EN
    perr_nx   = 1'b0;
`endif
    if (CLR) begin
      state_nx = IDLE;
      count_nx = '0;
    end else if (SEN) begin
      case (state)
        IDLE: begin
          dir_nx    = LEN;
          shift_dir = LEN;
          shift_en  = 1'b1;
          count_nx  = CW'(1);
          state_nx  = SHIFT;
        end
        SHIFT: begin
          shift_en = 1'b1;
          count_nx = count + CW'(1);
          if (count == CW'(W - 1)) begin
`ifdef DESER_PARITY_EN
            state_nx = PAR;
`else
            state_nx = IDLE;
            count_nx = '0;
            done     = 1'b1;
`endif
          end
        end
`ifdef DESER_PARITY_EN
        PAR: begin
          // Shift is idle here, so word_next is the held data word.
          state_nx = IDLE;
          count_nx = '0;
          if (^{word_next, SIN} == 1'b0) begin
            done = 1'b1;
          end else begin
            perr_nx = 1'b1;
          end
        end
`endif
        default: begin
          state_nx = IDLE;
          count_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state <= IDLE;
      count <= '0;
      dir   <= DIR_LSB_IN;
    end else begin
      state <= state_nx;
      count <= count_nx;
      dir   <= dir_nx;
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      Out <= '0;
      VLD <= 1'b0;
      OVR <= 1'b0;
    end else begin
      if (CLR) begin
        OVR <= 1'b0;
      end
      if (done) begin
        if (!VLD || RDY) begin
          Out <= word_next;
          VLD <= 1'b1;
        end else begin
          OVR <= 1'b1;
        end
      end else if (VLD && RDY) begin
        VLD <= 1'b0;
      end
    end
  end

`ifdef DESER_PARITY_EN
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      PERR <= 1'b0;
    end else begin
      PERR <= perr_nx;
    end
  end
`else
  assign PERR = 1'b0;
`endif

  assign BUSY = (count != '0);

endmodule

// File: doc/wbit_deserializer.md
# wbit_deserializer

Serial-to-parallel receiver for W-bit words. It collects strobed serial bits into a word, latches each completed word into a holding register, and presents it on a valid/ready handshake. It is the receiving end of the W-bit shift-register serial link. The datapath places the block between the serial line and the parallel register file / ALU input bus.

## Interface
- W, 4, data word width in bits (W ≥ 2)
- CLK  in  1  clock, rising edge active
- RES  in  1  reset, asynchronous, active-low
- SIN  in  1  serial data bit
- SEN  in  1  bit strobe; SIN is sampled on a rising edge only when SEN=1
- LEN  in  1  shift direction. 0: bits enter at the LSB and shift toward the MSB, so the first bit ends in the MSB. 1: bits enter at the MSB and shift toward the LSB, so the first bit ends in the LSB.
- CLR  in  1  synchronous abort: drops the partial word and clears OVR
- RDY  in  1  consumer ready
- Out  out W  holding register (received word)
- VLD  out 1  Out holds an unconsumed word
- BUSY out 1  partial word in progress (bit count ≠ 0)
- OVR  out 1  sticky overrun flag
- PERR out 1  one-cycle parity-error pulse (see Configuration)

## Operation
- FSM, in a shared package:
  - IDLE: count=0.
  - SHIFT: 0<count<W.
  - PAR: all W data bits held, parity bit expected. This state exists only with the macro defined.
- IDLE + SEN: latch LEN as the word direction, shift in SIN, count=1, go to SHIFT. LEN is ignored for the rest of the word.
- SHIFT + SEN: shift in SIN, count+1.
- Count reaching W:
  - Without the macro: the word is complete, return to IDLE.
  - With the macro: go to PAR.
- Completion:
  - If VLD=0, or VLD=1 with RDY=1 on the same edge: load Out with the word and set VLD=1.
  - Else: discard the new word, keep Out, set OVR=1.
- Handshake: a transfer occurs on an edge where VLD=1 and RDY=1.
  - VLD falls on that edge unless a completion loads a new word on the same edge; in that case VLD stays 1 and Out updates.
- CLR takes priority over SEN: the sampled bit is dropped, count=0, state=IDLE, OVR=0. CLR does not touch Out or VLD.
- The counter is ⌈log2(W+1)⌉ bits wide. No wrap beyond W.

## Timing
- Reset values: Out=0, VLD=0, BUSY=0, OVR=0, PERR=0, state=IDLE, count=0.
- Reset mid-word discards all progress immediately, asynchronously.
- Latency: VLD=1 in the cycle after the edge that samples the final bit (W-th data bit, or parity bit with the macro).
- SEN may be high on every cycle. Back-to-back words are received with no gap cycle.
- BUSY=1 from the cycle after the first bit until the cycle after completion.
- PERR is high for exactly the one cycle following the failing parity sample.

## Configuration
- DESER_PARITY_EN defined:
  - One extra SEN-strobed bit follows the W data bits; even parity over data plus parity bit.
  - Match: the word completes normally.
  - Mismatch: the word is discarded, PERR pulses, OVR and VLD are unaffected.
- Not defined:
  - No PAR state.
  - PERR is tied to 0.
  - A word completes on the W-th bit.

## Structure
- Package wbit_deser_pkg:
  - state enum (IDLE, SHIFT, PAR)
  - direction constants DIR_LSB_IN=0, DIR_MSB_IN=1
  - count-width function
- Sub-module deser_shift_core:
  - W-bit shift register with a direction input, serial input, shift enable and clear
  - Used for the in-progress word
- The top level holds the FSM, counter, holding register and flags.

## Test plan
- W=4, LEN=0, RDY=1, SEN=1 for 4 cycles with SIN=1,0,1,1 -> Out=4'b1011. VLD=1 for one cycle, the cycle after the 4th bit.
- Same bits with LEN=1 -> Out=4'b1101.
- RDY=0. Word 1011, then word 0110 fully received -> Out stays 1011 and OVR=1. Then RDY=1 -> transfer, and VLD=0 the next cycle.
- Reset pulse (RES=0) after 2 of 4 bits -> outputs at reset values, BUSY=0. The next 4 bits 0,1,1,0 with LEN=0 -> Out=4'b0110.
- CLR=1 together with SEN on the 3rd bit -> BUSY=0, OVR=0, Out unchanged. The next 4 bits form a complete word.
- With DESER_PARITY_EN:
  - Data 1011 + parity 1 -> Out=4'b1011, VLD=1.
  - Data 1011 + parity 0 -> PERR pulses one cycle, VLD stays 0.
